xoodoo_ctrl_sca: RTL and testbench
==================================

# xoodoo_ctrl_sca

Command sequencer for the first-order DOM-masked Xoodyak core. It sits directly upstream of the two-share Xoodoo state register. It accepts one command at a time:
- absorbs two-share 32-bit words from an input stream into the register;
- adds the domain constant into share 1 of word 11;
- steps the 12-round masked permutation by issuing per-round register loads;
- streams squeezed two-share words out through a valid/ready interface.

## Interface
Parameters:
- ROUND_CYCLES, 2, clock cycles per masked round (DOM pipeline depth); legal range 1..8
- NROUNDS, 12, permutation rounds

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=INIT, 1=ABSORB, 2=SQUEEZE, 3=PERMUTE
- cmd_len  in  4  word count 0..12; values >12 saturate to 12
- cmd_domain  in  32  domain constant, ABSORB only
- cmd_perm  in  1  ABSORB: permute after domain add; SQUEEZE: permute before output
- din_data  in  64  {share0, share1} input word
- din_valid  in  1  input word offered
- din_ready  out  1  input word accepted this cycle when din_valid is also high
- dout_data  out  64  {share0, share1} squeezed word
- dout_valid  out  1  output word offered
- dout_ready  in  1  output word consumed
- reg_word_in  in  64  register read port for the current word_index_o
- word_out_o  out  64  data written into the register (din_data passthrough)
- word_index_o  out  4  register word index
- word_enable_o  out  1  register word XOR-write strobe
- domain_o  out  32  domain constant to the register
- domain_enable_o  out  1  domain XOR strobe
- reg_en_o  out  1  register loads the round-function output
- init_o  out  1  register clear
- round_idx_o  out  4  round index 0..11, drives the round-constant lookup
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on return to IDLE

## Operation
States: IDLE, INIT, ABSORB, DOMAIN, PERM, SQUEEZE.
- IDLE: cmd_ready=1. A cmd_valid&&cmd_ready handshake latches op, saturated len, domain and perm. The next state is selected as follows:
  - INIT -> INIT.
  - ABSORB -> ABSORB if len>0, else DOMAIN.
  - SQUEEZE with perm=1 -> PERM.
  - SQUEEZE with perm=0 -> SQUEEZE if len>0, else IDLE.
  - PERMUTE -> PERM.
- INIT: init_o=1 for one cycle, then IDLE.
- ABSORB: word counter wc starts at 0.
  - din_ready=1; word_index_o=wc; word_out_o=din_data; word_enable_o=din_valid.
  - On each handshake wc increments.
  - After the handshake with wc==len-1, go to DOMAIN.
- DOMAIN: domain_enable_o=1 for exactly one cycle (also when domain==0). Next is PERM if perm=1, else IDLE.
- PERM: round counter r runs 0..NROUNDS-1; cycle counter c runs 0..ROUND_CYCLES-1.
  - round_idx_o=r.
  - reg_en_o=1 only when c==ROUND_CYCLES-1; r then increments and c returns to 0.
  - After the load for r==NROUNDS-1, go to SQUEEZE if the op is SQUEEZE and len>0, else IDLE.
- SQUEEZE: dout_valid=1; word_index_o=wc; dout_data=reg_word_in (combinational pass-through).
  - wc increments on dout_ready.
  - After the handshake with wc==len-1, go to IDLE.
  - The register is never written in this state.
- Strobe exclusivity: word_enable_o, domain_enable_o, reg_en_o and init_o are mutually exclusive in every cycle. This guarantees word 11 is never hit by a word write and a domain add in the same cycle.
- din_ready=0 outside ABSORB; dout_valid=0 outside SQUEEZE.
- done_o pulses in the first IDLE cycle after any command completes.

## Timing
- Reset: all outputs 0 during rst, including cmd_ready, all data and index outputs, and all counters. The first cycle after rst deasserts is IDLE with cmd_ready=1.
- A rst asserted mid-command aborts it: the FSM returns to IDLE with no further strobes, and no done_o pulse is issued.
- Command accept to first strobe: 1 cycle.
- ABSORB of n words with ideal flow: n cycles + 1 DOMAIN cycle.
- PERM: NROUNDS*ROUND_CYCLES cycles, with exactly NROUNDS reg_en_o pulses.
- Stalls:
  - din_valid=0 holds wc with no strobe.
  - dout_ready=0 holds dout_data stable and dout_valid high.
- word_index_o is 0 in all states except ABSORB and SQUEEZE.

## Structure
- Shared package xoodyak_sca_pkg holds the op encodings (OP_INIT, OP_ABSORB, OP_SQUEEZE, OP_PERMUTE), the state encoding, MAX_WORDS=12 and NROUNDS=12.
- Single flat module; no sub-module.
- The round datapath and the round-constant ROM are external.

## Test plan
- Reset, then INIT: init_o high for exactly 1 cycle; done_o follows next cycle; cmd_ready=1 afterwards.
- ABSORB len=4, domain=0x03, perm=0, din_valid constant:
  - word_enable_o on indices 0,1,2,3 with matching din_data;
  - then domain_enable_o with domain_o=0x03 for 1 cycle;
  - 6 cycles from accept to done_o.
- ABSORB len=12, perm=1, ROUND_CYCLES=2, with din_valid dropped on every other cycle:
  - index advances only on handshakes;
  - then 24 PERM cycles with reg_en_o on cycles 2,4,…,24;
  - round_idx_o steps 0..11.
- SQUEEZE len=2, perm=1 with register model: 12 reg_en_o pulses, then dout_data = register words 0 and 1. dout_ready low for 3 cycles holds the first word stable.
- Edge cases:
  - ABSORB len=0: DOMAIN only.
  - len=15 saturates to 12 words.
  - SQUEEZE len=0 with perm=0: immediate done.
- rst asserted in PERM round 5: all strobes drop; IDLE follows; no done_o; a following INIT is accepted normally.

Source files
------------

// File: rtl/xoodyak_sca_pkg.sv
// Shared encodings for the masked Xoodyak controller: command ops, FSM states, and sizes.
package xoodyak_sca_pkg;

  localparam logic [1:0] OP_INIT    = 2'd0;
  localparam logic [1:0] OP_ABSORB  = 2'd1;
  localparam logic [1:0] OP_SQUEEZE = 2'd2;
  localparam logic [1:0] OP_PERMUTE = 2'd3;

  localparam int unsigned MAX_WORDS = 12;
  localparam int unsigned NROUNDS   = 12;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StAbsorb,
    StDomain,
    StPerm,
    StSqueeze
  } state_e;

  function automatic logic [3:0] sat_len(input logic [3:0] len);
    return (len > 4'(MAX_WORDS)) ? 4'(MAX_WORDS) : len;
  endfunction

endpackage

// File: rtl/xoodoo_ctrl_sca.sv
// Command sequencer for the two-share Xoodoo state: absorb, domain add, masked permutation
// stepping and squeeze, one command at a time.
module xoodoo_ctrl_sca #(
  parameter int unsigned ROUND_CYCLES = 2,
  parameter int unsigned NROUNDS      = xoodyak_sca_pkg::NROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] cmd_domain,
  input  logic        cmd_perm,
  input  logic [63:0] din_data,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [63:0] dout_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic [63:0] reg_word_in,
  output logic [63:0] word_out_o,
  output logic [3:0]  word_index_o,
  output logic        word_enable_o,
  output logic [31:0] domain_o,
  output logic        domain_enable_o,
  output logic        reg_en_o,
  output logic        init_o,
  output logic [3:0]  round_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  import xoodyak_sca_pkg::*;

  localparam logic [2:0] CycLast   = 3'(ROUND_CYCLES - 1);
  localparam logic [3:0] RoundLast = 4'(NROUNDS - 1);

  state_e      state_q;
  logic [1:0]  op_q;
  logic [3:0]  len_q;
  logic [31:0] dom_q;
  logic        perm_q;
  logic [3:0]  wc_q;
  logic [3:0]  rnd_q;
  logic [2:0]  cyc_q;
  logic        done_q;

  logic [3:0]  len_sat;
  logic        last_word;
  logic        round_load;

  assign len_sat    = sat_len(cmd_len);
  assign last_word  = (wc_q == len_q - 4'd1);
  assign round_load = (cyc_q == CycLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      len_q   <= '0;
      dom_q   <= '0;
      perm_q  <= 1'b0;
      wc_q    <= '0;
      rnd_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            len_q  <= len_sat;
            dom_q  <= cmd_domain;
            perm_q <= cmd_perm;
            wc_q   <= '0;
            rnd_q  <= '0;
            cyc_q  <= '0;
            unique case (cmd_op)
              OP_INIT:   state_q <= StInit;
              OP_ABSORB: state_q <= (len_sat != 4'd0) ? StAbsorb : StDomain;
              OP_SQUEEZE: begin
                if (cmd_perm) begin
                  state_q <= StPerm;
                end else if (len_sat != 4'd0) begin
                  state_q <= StSqueeze;
                end else begin
                  // Nothing to do: complete without leaving IDLE.
                  done_q <= 1'b1;
                end
              end
              default:   state_q <= StPerm;
            endcase
          end
        end
        StInit: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        StAbsorb: begin
          if (din_valid) begin
            if (last_word) begin
              wc_q    <= '0;
              state_q <= StDomain;
            end else begin
              wc_q <= wc_q + 4'd1;
            end
          end
        end
        StDomain: begin
          if (perm_q) begin
            state_q <= StPerm;
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StPerm: begin
          if (round_load) begin
            cyc_q <= '0;
            if (rnd_q == RoundLast) begin
              rnd_q <= '0;
              if (op_q == OP_SQUEEZE && len_q != 4'd0) begin
                wc_q    <= '0;
                state_q <= StSqueeze;
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end else begin
            cyc_q <= cyc_q + 3'd1;
          end
        end
        StSqueeze: begin
          if (dout_ready) begin
            if (last_word) begin
              wc_q    <= '0;
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              wc_q <= wc_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Every output is forced low while rst is held, whatever state the FSM is in.
  always_comb begin
    cmd_ready       = 1'b0;
    din_ready       = 1'b0;
    dout_data       = '0;
    dout_valid      = 1'b0;
    word_out_o      = '0;
    word_index_o    = '0;
    word_enable_o   = 1'b0;
    domain_o        = '0;
    domain_enable_o = 1'b0;
    reg_en_o        = 1'b0;
    init_o          = 1'b0;
    round_idx_o     = '0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    if (!rst) begin
      cmd_ready = (state_q == StIdle);
      busy_o    = (state_q != StIdle);
      done_o    = done_q;
      domain_o  = dom_q;
      unique case (state_q)
        StInit:   init_o = 1'b1;
        StAbsorb: begin
          din_ready     = 1'b1;
          word_index_o  = wc_q;
          word_out_o    = din_data;
          word_enable_o = din_valid;
        end
        StDomain: domain_enable_o = 1'b1;
        StPerm: begin
          round_idx_o = rnd_q;
          reg_en_o    = round_load;
        end
        StSqueeze: begin
          dout_valid   = 1'b1;
          word_index_o = wc_q;
          dout_data    = reg_word_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_ctrl_sca.sv
// Scoreboard bench for xoodoo_ctrl_sca: stimulus pushes expected strobe events with their
// cycle numbers; a negedge monitor pops and compares whenever the DUT strobes.
module tb_xoodoo_ctrl_sca;
  import xoodyak_sca_pkg::*;

  localparam int RC = 2;
  localparam int EvInit = 0, EvWord = 1, EvDom = 2, EvReg = 3, EvOut = 4, EvDone = 5;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_perm;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_domain;
  logic [63:0] din_data, dout_data, reg_word_in, word_out_o;
  logic        din_valid, din_ready, dout_valid, dout_ready;
  logic [3:0]  word_index_o, round_idx_o;
  logic        word_enable_o, domain_enable_o, reg_en_o, init_o, busy_o, done_o;
  logic [31:0] domain_o;

  xoodoo_ctrl_sca #(.ROUND_CYCLES(RC), .NROUNDS(12)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_domain(cmd_domain), .cmd_perm(cmd_perm), .din_data(din_data),
    .din_valid(din_valid), .din_ready(din_ready), .dout_data(dout_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .reg_word_in(reg_word_in),
    .word_out_o(word_out_o), .word_index_o(word_index_o), .word_enable_o(word_enable_o),
    .domain_o(domain_o), .domain_enable_o(domain_enable_o), .reg_en_o(reg_en_o),
    .init_o(init_o), .round_idx_o(round_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int          kind;
    logic [3:0]  idx;
    logic [63:0] data;
    longint      cyc;
  } ev_t;

  ev_t    sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Two-share state register model; the "round" adds round_idx+1 to every word.
  logic [63:0] regs [16];
  initial for (int i = 0; i < 16; i++) regs[i] = '0;
  assign reg_word_in = regs[word_index_o];
  always @(posedge clk) begin
    if (init_o) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (word_enable_o) begin
      regs[word_index_o] <= regs[word_index_o] ^ word_out_o;
    end else if (domain_enable_o) begin
      regs[11] <= regs[11] ^ {32'h0, domain_o};
    end else if (reg_en_o) begin
      for (int i = 0; i < 12; i++) regs[i] <= regs[i] + 64'(round_idx_o) + 64'd1;
    end
  end

  function automatic string kname(input int k);
    case (k)
      EvInit:  return "init";
      EvWord:  return "word";
      EvDom:   return "domain";
      EvReg:   return "reg_en";
      EvOut:   return "dout";
      default: return "done";
    endcase
  endfunction

  function automatic void push(input int kind, input logic [3:0] idx, input logic [63:0] data,
                               input longint cyc);
    ev_t e;
    e.kind = kind; e.idx = idx; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endfunction

  task automatic observe(input int kind, input logic [3:0] idx, input logic [63:0] data);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got idx=%0d data=%h at cycle %0d, required no event",
               kname(kind), idx, data, cyc_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.idx != idx || e.data != data || e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL event_%s: got %s idx=%0d data=%h cyc=%0d, required %s idx=%0d data=%h cyc=%0d",
                 kname(e.kind), kname(kind), idx, data, cyc_cnt, kname(e.kind), e.idx, e.data,
                 e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    int n;
    n = int'(init_o) + int'(word_enable_o) + int'(domain_enable_o) + int'(reg_en_o);
    if (n > 0) begin
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL strobe_exclusive: got %0d strobes at cycle %0d, required 1", n, cyc_cnt);
      end
    end
    if (init_o)                  observe(EvInit, 4'd0, 64'd0);
    if (word_enable_o)           observe(EvWord, word_index_o, word_out_o);
    if (domain_enable_o)         observe(EvDom, 4'd0, {32'h0, domain_o});
    if (reg_en_o)                observe(EvReg, round_idx_o, 64'd0);
    if (dout_valid && dout_ready) observe(EvOut, word_index_o, dout_data);
    if (done_o)                  observe(EvDone, 4'd0, 64'd0);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending events, required 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] len, input logic [31:0] dom,
                       input logic perm, output longint acc);
    @(posedge clk); #1;
    cmd_op = op; cmd_len = len; cmd_domain = dom; cmd_perm = perm; cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc = cyc_cnt;
  endtask

  function automatic void push_perm(input longint t0);
    for (int k = 0; k < 12; k++) push(EvReg, 4'(k), 64'd0, t0 + longint'(RC * k + RC - 1));
  endfunction

  task automatic absorb(input logic [3:0] len, input int n, input logic [31:0] dom,
                        input logic perm, input logic stall, input logic [63:0] base);
    longint acc, t;
    int     k, guard;
    logic   hs;
    din_data  = base;
    din_valid = 1'b1;
    issue(OP_ABSORB, len, dom, perm, acc);
    for (int i = 0; i < n; i++)
      push(EvWord, 4'(i), base + 64'(i), stall ? acc + 2 * i : acc + i);
    if (n == 0) t = acc;
    else        t = (stall ? acc + 2 * (n - 1) : acc + (n - 1)) + 1;
    push(EvDom, 4'd0, {32'h0, dom}, t);
    if (perm) begin
      push_perm(t + 1);
      push(EvDone, 4'd0, 64'd0, t + 1 + 12 * RC);
    end else begin
      push(EvDone, 4'd0, 64'd0, t + 1);
    end
    k = 0;
    guard = 0;
    while (k < n && guard < 200) begin
      din_valid = stall ? ((cyc_cnt - acc) % 2 == 0) : 1'b1;
      din_data  = base + 64'(k);
      @(negedge clk);
      hs = din_valid && din_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    din_valid = 1'b0;
    din_data  = '0;
    drain("absorb");
  endtask

  task automatic do_init();
    longint acc;
    issue(OP_INIT, 4'd0, 32'd0, 1'b0, acc);
    push(EvInit, 4'd0, 64'd0, acc);
    push(EvDone, 4'd0, 64'd0, acc + 1);
    drain("init");
  endtask

  initial begin : wdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

  initial begin : stim
    longint acc;
    logic [63:0] sq_base;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_domain = '0; cmd_perm = 1'b0;
    din_data = '0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'(|{cmd_ready, din_ready, dout_data, dout_valid, word_out_o,
                             word_index_o, word_enable_o, domain_o, domain_enable_o, reg_en_o,
                             init_o, round_idx_o, busy_o, done_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_busy", 64'(busy_o), 64'd0);

    do_init();
    @(negedge clk);
    chk("init_cmd_ready_after", 64'(cmd_ready), 64'd1);

    absorb(4'd4, 4, 32'h0000_0003, 1'b0, 1'b0, 64'hC0DE_0000_1111_0000);
    absorb(4'd12, 12, 32'h0000_0001, 1'b1, 1'b1, 64'hFACE_0000_0000_0100);
    absorb(4'd0, 0, 32'h0000_0000, 1'b0, 1'b0, 64'h0);
    absorb(4'd15, 12, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0BAD_F00D_0000_0000);

    issue(OP_SQUEEZE, 4'd0, 32'd0, 1'b0, acc);
    push(EvDone, 4'd0, 64'd0, acc);
    drain("squeeze_len0");

    // Words 0/1 start as base and base+1; 12 rounds add 1+2+...+12 = 78 = 0x4e.
    do_init();
    sq_base = 64'h0123_4567_89AB_CDEF;
    absorb(4'd2, 2, 32'h0000_0005, 1'b0, 1'b0, sq_base);
    dout_ready = 1'b0;
    issue(OP_SQUEEZE, 4'd2, 32'd0, 1'b1, acc);
    push_perm(acc);
    push(EvOut, 4'd0, 64'h0123_4567_89AB_CE3D, acc + 27);
    push(EvOut, 4'd1, 64'h0123_4567_89AB_CE3E, acc + 28);
    push(EvDone, 4'd0, 64'd0, acc + 29);
    repeat (24) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sq_stall_valid", 64'(dout_valid), 64'd1);
      chk("sq_stall_data", dout_data, 64'h0123_4567_89AB_CE3D);
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    drain("squeeze");
    dout_ready = 1'b0;

    // Abort PERMUTE at the start of round 5.
    issue(OP_PERMUTE, 4'd0, 32'd0, 1'b0, acc);
    for (int k = 0; k < 5; k++) push(EvReg, 4'(k), 64'd0, acc + 2 * k + 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_outputs", 64'(|{cmd_ready, din_ready, dout_valid, word_enable_o,
                                   domain_enable_o, reg_en_o, init_o, round_idx_o, busy_o,
                                   done_o}), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_no_done", 64'(done_o), 64'd0);
    drain("abort");
    do_init();

    repeat (3) @(posedge clk);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
